// File: rtl/olord_ctl.sv
// ---------------------------------------------------------------------------
// olord_ctl -- parametrised overlord control for the CADR core.
//
// Collects NSRC maskable error sources into sticky per-source bits and
// remembers the index of the first error captured. Runs programmed or
// external reset/boot sequences with a stretched cpu_reset pulse. Drives
// boot_trap, err/errhalt and the statistics stop to the sequencer and spy
// logic.
//
// Optional feature: define OLORD_ERRCNT_EN to add the saturating err_count
// output and its counter logic. When it is undefined there is no err_count
// port and no counter.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   spy_in     in   [15:0] spy write data, decoded when ldmode=1 in IDLE
//                   [7] boot, [6] reset sequence, [5] clear errors,
//                   [4] clear statstop
//   ldmode     in   spy mode-register write strobe
//   err_src    in   [NSRC-1:0] raw error sources, level, active-high
//   err_mask   in   [NSRC-1:0] 1 = source ignored for capture
//   errstop    in   enable halt on error
//   ext_boot   in   external boot request, level (rising edge acts)
//   srun       in   sequencer running, clears boot_trap
//   stat_ovf   in   statistics counter overflow
//   cpu_reset  out  reset to processor datapath, high in every RST cycle
//   boot       out  one-cycle boot strobe
//   boot_trap  out  sticky: boot occurred, sequencer not yet running
//   err        out  OR of err_vec
//   errhalt    out  errstop & err
//   err_vec    out  [NSRC-1:0] sticky per-source error bits
//   err_first  out  [IDXW-1:0] index of first captured error
//   statstop   out  sticky statistics stop
//   busy       out  sequencer not idle
//   err_count  out  [7:0] saturating error count (OLORD_ERRCNT_EN only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module olord_ctl #(
  parameter int NSRC       = 4,
  parameter int RST_CYCLES = 16,
  parameter int IDXW       = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     spy_in,
  input  logic            ldmode,
  input  logic [NSRC-1:0] err_src,
  input  logic [NSRC-1:0] err_mask,
  input  logic            errstop,
  input  logic            ext_boot,
  input  logic            srun,
  input  logic            stat_ovf,
  output logic            cpu_reset,
  output logic            boot,
  output logic            boot_trap,
  output logic            err,
  output logic            errhalt,
  output logic [NSRC-1:0] err_vec,
  output logic [IDXW-1:0] err_first,
  output logic            statstop,
`ifdef OLORD_ERRCNT_EN
  output logic [7:0]      err_count,
`endif
  output logic            busy
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_BOOT = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   rst_cnt;
  logic            boot_pend;
  logic            ext_prev;

  logic            idle;
  logic            cmd;
  logic            ext_rise;
  logic            clr_err;
  logic            clr_stat;
  logic [NSRC-1:0] new_err;
  logic [NSRC-1:0] err_base;

  // Lowest set bit index of a source vector; 0 when the vector is empty.
  function automatic logic [IDXW-1:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [IDXW-1:0] idx;
    idx = {IDXW{1'b0}};
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDXW'(i);
      end
    end
    return idx;
  endfunction

  // Spy commands and external boot edges only act while the sequencer is idle.
  assign idle     = (state == S_IDLE);
  assign cmd      = ldmode & idle;
  assign ext_rise = ext_boot & ~ext_prev & idle;
  assign clr_err  = cmd & spy_in[5];
  assign clr_stat = cmd & spy_in[4];
  assign new_err  = err_src & ~err_mask;
  // A clear in the same cycle as a new error restarts capture from the new error.
  assign err_base = clr_err ? {NSRC{1'b0}} : err_vec;

  assign err     = |err_vec;
  assign errhalt = errstop & err;

  // Reset/boot sequencer with registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rst_cnt   <= {CW{1'b0}};
      boot_pend <= 1'b0;
      ext_prev  <= 1'b0;
      cpu_reset <= 1'b0;
      boot      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ext_prev <= ext_boot;
      case (state)
        S_IDLE: begin
          if (cmd & spy_in[6]) begin
            state     <= S_RST;
            rst_cnt   <= CW'(RST_CYCLES);
            boot_pend <= spy_in[7] | ext_rise;
            cpu_reset <= 1'b1;
            boot      <= 1'b0;
            busy      <= 1'b1;
          end else if ((cmd & spy_in[7]) | ext_rise) begin
            state     <= S_BOOT;
            cpu_reset <= 1'b0;
            boot      <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state     <= S_IDLE;
            cpu_reset <= 1'b0;
            boot      <= 1'b0;
            busy      <= 1'b0;
          end
        end
        S_RST: begin
          // rst_cnt counts the RST cycles still to run, this one included.
          if (rst_cnt == CW'(1)) begin
            boot_pend <= 1'b0;
            cpu_reset <= 1'b0;
            if (boot_pend) begin
              state <= S_BOOT;
              boot  <= 1'b1;
              busy  <= 1'b1;
            end else begin
              state <= S_IDLE;
              boot  <= 1'b0;
              busy  <= 1'b0;
            end
          end else begin
            rst_cnt <= rst_cnt - CW'(1);
          end
        end
        S_BOOT: begin
          state     <= S_IDLE;
          cpu_reset <= 1'b0;
          boot      <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= S_IDLE;
          cpu_reset <= 1'b0;
          boot      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error capture, first-error index, statistics stop and boot trap.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_vec   <= {NSRC{1'b0}};
      err_first <= {IDXW{1'b0}};
      statstop  <= 1'b0;
      boot_trap <= 1'b0;
    end else begin
      if (state == S_RST) begin
        err_vec   <= {NSRC{1'b0}};
        err_first <= {IDXW{1'b0}};
        statstop  <= 1'b0;
      end else begin
        err_vec <= err_base | new_err;
        if ((err_base == {NSRC{1'b0}}) && (new_err != {NSRC{1'b0}})) begin
          err_first <= lowest_idx(new_err);
        end else if (clr_err) begin
          err_first <= {IDXW{1'b0}};
        end else begin
          err_first <= err_first;
        end
        // Overflow wins over a clear in the same cycle.
        if (stat_ovf) begin
          statstop <= 1'b1;
        end else if (clr_stat) begin
          statstop <= 1'b0;
        end else begin
          statstop <= statstop;
        end
      end
      if (state == S_BOOT) begin
        boot_trap <= 1'b1;
      end else if (srun) begin
        boot_trap <= 1'b0;
      end else begin
        boot_trap <= boot_trap;
      end
    end
  end

`ifdef OLORD_ERRCNT_EN
  // Saturating count of cycles that raise a not-yet-captured error bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if ((state == S_RST) || clr_err) begin
      err_count <= 8'd0;
    end else if (((new_err & ~err_vec) != {NSRC{1'b0}}) && (err_count != 8'd255)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end
`endif

endmodule

// File: tb/tb_olord_ctl.sv
`timescale 1ns/1ps
module tb_olord_ctl;

  localparam int NSRC = 4;
  localparam int RSTC = 16;
  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [15:0]     spy_in;
  logic            ldmode;
  logic [NSRC-1:0] err_src;
  logic [NSRC-1:0] err_mask;
  logic            errstop;
  logic            ext_boot;
  logic            srun;
  logic            stat_ovf;
  logic            cpu_reset;
  logic            boot;
  logic            boot_trap;
  logic            err;
  logic            errhalt;
  logic [NSRC-1:0] err_vec;
  logic [IDXW-1:0] err_first;
  logic            statstop;
  logic            busy;
`ifdef OLORD_ERRCNT_EN
  logic [7:0]      err_count;
`endif

  olord_ctl #(.NSRC(NSRC), .RST_CYCLES(RSTC), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .spy_in(spy_in), .ldmode(ldmode),
    .err_src(err_src), .err_mask(err_mask), .errstop(errstop),
    .ext_boot(ext_boot), .srun(srun), .stat_ovf(stat_ovf),
    .cpu_reset(cpu_reset), .boot(boot), .boot_trap(boot_trap),
    .err(err), .errhalt(errhalt), .err_vec(err_vec), .err_first(err_first),
    .statstop(statstop),
`ifdef OLORD_ERRCNT_EN
    .err_count(err_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            cpu_reset;
    logic            boot;
    logic            boot_trap;
    logic            err;
    logic            errhalt;
    logic [NSRC-1:0] err_vec;
    logic [IDXW-1:0] err_first;
    logic            statstop;
    logic            busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: remaining reset cycles, boot due next, sticky flags.
  int              m_rst_left;
  bit              m_boot_now;
  bit              m_boot_after;
  bit              m_trap;
  bit              m_stat;
  bit              m_prev;
  logic [NSRC-1:0] m_errv;
  int              m_first;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Advance the model over the coming clock edge and queue the outputs it predicts.
  task automatic model_step();
    bit idle, cmd, rise, was_rst, was_boot, clr_e, clr_s;
    logic [NSRC-1:0] nw, base;
    exp_t e;
    if (reset) begin
      m_rst_left = 0; m_boot_now = 0; m_boot_after = 0; m_trap = 0;
      m_stat = 0; m_prev = 0; m_errv = '0; m_first = 0;
    end else begin
      was_rst  = (m_rst_left > 0);
      was_boot = m_boot_now;
      idle     = !was_rst && !was_boot;
      cmd      = ldmode && idle;
      rise     = ext_boot && !m_prev;
      clr_e    = cmd && spy_in[5];
      clr_s    = cmd && spy_in[4];
      if (was_rst) begin
        m_errv = '0; m_first = 0; m_stat = 0;
      end else begin
        nw   = err_src & ~err_mask;
        base = clr_e ? '0 : m_errv;
        if (base == 0 && nw != 0) begin
          for (int i = NSRC - 1; i >= 0; i--) if (nw[i]) m_first = i;
        end else if (clr_e) begin
          m_first = 0;
        end
        m_errv = base | nw;
        if (stat_ovf) m_stat = 1;
        else if (clr_s) m_stat = 0;
      end
      if (was_boot) m_trap = 1;
      else if (srun) m_trap = 0;
      if (idle) begin
        if (cmd && spy_in[6]) begin
          m_rst_left = RSTC;
          m_boot_after = spy_in[7] || rise;
        end else if ((cmd && spy_in[7]) || rise) begin
          m_boot_now = 1;
        end
      end else if (was_rst) begin
        m_rst_left--;
        if (m_rst_left == 0) begin
          m_boot_now = m_boot_after;
          m_boot_after = 0;
        end
      end else begin
        m_boot_now = 0;
      end
      m_prev = ext_boot;
    end
    e.cpu_reset = (m_rst_left > 0);
    e.boot      = m_boot_now;
    e.boot_trap = m_trap;
    e.err       = (m_errv != 0);
    e.errhalt   = errstop && (m_errv != 0);
    e.err_vec   = m_errv;
    e.err_first = IDXW'(m_first);
    e.statstop  = m_stat;
    e.busy      = (m_rst_left > 0) || m_boot_now;
    q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  // Monitor: after each active edge, pop the prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cpu_reset", int'(cpu_reset), int'(e.cpu_reset));
        chk("boot",      int'(boot),      int'(e.boot));
        chk("boot_trap", int'(boot_trap), int'(e.boot_trap));
        chk("err",       int'(err),       int'(e.err));
        chk("errhalt",   int'(errhalt),   int'(e.errhalt));
        chk("err_vec",   int'(err_vec),   int'(e.err_vec));
        chk("err_first", int'(err_first), int'(e.err_first));
        chk("statstop",  int'(statstop),  int'(e.statstop));
        chk("busy",      int'(busy),      int'(e.busy));
      end
    end
  end

  initial begin
    reset = 1'b1; spy_in = 16'h0000; ldmode = 1'b0; err_src = '0; err_mask = '0;
    errstop = 1'b0; ext_boot = 1'b0; srun = 1'b0; stat_ovf = 1'b0;
    m_rst_left = 0; m_boot_now = 0; m_boot_after = 0; m_trap = 0;
    m_stat = 0; m_prev = 0; m_errv = '0; m_first = 0;

    // Reset for two cycles.
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset sequence followed by boot, then srun releases boot_trap.
    ldmode = 1'b1; spy_in = 16'h00C0; tick();
    ldmode = 1'b0; spy_in = 16'h0000;
    repeat (22) tick();
    srun = 1'b1; tick();
    srun = 1'b0; tick();

    // Masked capture, first index, errhalt and clear.
    err_mask = 4'b0010; err_src = 4'b0110; tick();
    err_src = 4'b0000; errstop = 1'b1; tick(); tick();
    ldmode = 1'b1; spy_in = 16'h0020; tick();
    ldmode = 1'b0; spy_in = 16'h0000; errstop = 1'b0; err_mask = '0; tick();

    // Reset command while busy is ignored.
    ldmode = 1'b1; spy_in = 16'h0040; tick();
    ldmode = 1'b0; tick(); tick(); tick();
    ldmode = 1'b1; spy_in = 16'h0040; tick();
    ldmode = 1'b0; spy_in = 16'h0000;
    repeat (20) tick();

    // Overflow beats clear; clear alone drops statstop.
    stat_ovf = 1'b1; ldmode = 1'b1; spy_in = 16'h0010; tick();
    stat_ovf = 1'b0; ldmode = 1'b0; tick();
    ldmode = 1'b1; tick();
    ldmode = 1'b0; spy_in = 16'h0000; tick();

    // External boot rising edge.
    ext_boot = 1'b1; tick(); tick(); tick();
    ext_boot = 1'b0; tick();

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      ldmode   = ($urandom_range(0, 9) == 0);
      spy_in   = 16'($urandom_range(0, 15)) << 4;
      err_src  = ($urandom_range(0, 5) == 0) ? NSRC'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) err_mask = NSRC'($urandom);
      errstop  = 1'($urandom);
      if ($urandom_range(0, 19) == 0) ext_boot = ~ext_boot;
      srun     = ($urandom_range(0, 15) == 0);
      stat_ovf = ($urandom_range(0, 29) == 0);
      tick();
    end
    reset = 1'b0; ldmode = 1'b0; tick(); tick();

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
